// File: rtl/binop_pkg.sv
// Shared types for the BinOp result-statistics datapath: state encoding and the
// result record layout consumed by later stages.
package binop_pkg;

    localparam int BINOP_DATA_W = 16;
    localparam int BINOP_ACC_W  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } accum_state_t;

    typedef struct packed {
        logic [BINOP_ACC_W-1:0]  sum;
        logic [BINOP_DATA_W-1:0] min;
        logic [BINOP_DATA_W-1:0] max;
        logic                    ovf;
    } accum_rec_t;

endpackage

// File: rtl/binop_acc_add.sv
// Combinational window accumulator adder with carry-out.
// Build option BINOP_ACC_SAT_EN: clamp the sum at all-ones once the window has overflowed.
module binop_acc_add #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 24
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] sample,
    input  logic              ovf_prev,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] wide;

    assign wide  = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, sample};
    assign carry = wide[ACC_W];

`ifdef BINOP_ACC_SAT_EN
    // Once saturated the accumulator stays pinned for the rest of the window.
    assign sum = (carry | ovf_prev) ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    logic unused_ovf_prev;
    assign unused_ovf_prev = ovf_prev;
    assign sum             = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/binop_result_accum.sv
// Reduces each WINDOW-sample burst of BinOp results to a sum/min/max/overflow record
// behind valid/ready handshakes. Saturating sum selected by BINOP_ACC_SAT_EN (see binop_acc_add).
module binop_result_accum
    import binop_pkg::*;
#(
    parameter int DATA_W = BINOP_DATA_W,
    parameter int WINDOW = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] xin,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic [DATA_W-1:0] min,
    output logic [DATA_W-1:0] max,
    output logic              ovf
);

    localparam int CNT_W = 16;

    accum_state_t      state_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [DATA_W-1:0] lo_reg;
    logic [DATA_W-1:0] hi_reg;
    logic              ovf_acc_reg;

    logic [ACC_W-1:0]  add_sum;
    logic              add_carry;
    logic [DATA_W-1:0] lo_next;
    logic [DATA_W-1:0] hi_next;
    logic              ovf_next;
    logic              last_sample;

    binop_acc_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc      (acc_reg),
        .sample   (xin),
        .ovf_prev (ovf_acc_reg),
        .sum      (add_sum),
        .carry    (add_carry)
    );

    assign in_ready    = (state_reg != EMIT);
    assign lo_next     = (xin < lo_reg) ? xin : lo_reg;
    assign hi_next     = (xin > hi_reg) ? xin : hi_reg;
    assign ovf_next    = ovf_acc_reg | add_carry;
    assign last_sample = (count_reg == CNT_W'(WINDOW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            acc_reg     <= '0;
            lo_reg      <= '0;
            hi_reg      <= '0;
            ovf_acc_reg <= 1'b0;
            out_valid   <= 1'b0;
            sum         <= '0;
            min         <= '0;
            max         <= '0;
            ovf         <= 1'b0;
        end else if (clear) begin
            // Abort wins over any coincident input or output transfer.
            state_reg <= IDLE;
            count_reg <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        acc_reg     <= ACC_W'(xin);
                        lo_reg      <= xin;
                        hi_reg      <= xin;
                        ovf_acc_reg <= 1'b0;
                        count_reg   <= CNT_W'(1);
                        state_reg   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_reg     <= add_sum;
                        lo_reg      <= lo_next;
                        hi_reg      <= hi_next;
                        ovf_acc_reg <= ovf_next;
                        if (last_sample) begin
                            sum       <= add_sum;
                            min       <= lo_next;
                            max       <= hi_next;
                            ovf       <= ovf_next;
                            out_valid <= 1'b1;
                            count_reg <= '0;
                            state_reg <= EMIT;
                        end else begin
                            count_reg <= count_reg + CNT_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
